load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store unit between the EX/MEM pipeline stage and the data RAM. It turns a `mem_read_t`/`mem_write_t` request into one or two word-aligned bus transactions with byte enables, and builds sign- or zero-extended load results. Misaligned accesses are either split into two transactions or faulted, selected by a parameter. Accesses outside the RAM window fault without touching the bus. The pipeline stalls on `req_ready`/`rsp_valid`.

## Interface
- `RAM_BASE`, default 32'h0000_1000: first legal byte address.
- `RAM_SIZE`, default 32'h0000_2000: window size in bytes. The window is [RAM_BASE, RAM_BASE+RAM_SIZE).
- `SPLIT_MISALIGNED`, default 1: 1 = split line-crossing accesses into two transactions; 0 = fault them.
- `BAD_DATA`, default 32'hdead_beef: `rsp_rdata` value on any fault.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; the request is accepted when valid & ready.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_read` in 3: `mem_read_t` encoding.
- `req_write` in 2: `mem_write_t` encoding.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data. It is 0 for stores.
- `rsp_fault` out 1: access fault; qualified by `rsp_valid`.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: word-aligned bus address.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_gnt` in 1: bus has taken the request.
- `mem_rvalid` in 1: bus response; for reads it carries `mem_rdata`, for writes it is the acknowledge.
- `mem_rdata` in 32: read word.

## Operation
- **States:**
  - IDLE. `req_ready`=1. On accept, the request is latched:
    - A fault goes to DONE.
    - NONE/NONE goes to DONE with no fault and data 0.
    - Otherwise go to ISSUE0.
  - ISSUE0 / ISSUE1. `mem_req`=1. Go to WAIT0 / WAIT1 on `mem_gnt`.
  - WAIT0. On `mem_rvalid`, capture the word. Go to ISSUE1 if the access is split, else DONE.
  - WAIT1. On `mem_rvalid`, capture the word. Go to DONE.
  - DONE. `rsp_valid`=1 for one cycle. Go to IDLE.
- **Offset and size:** off = addr[1:0]. Size is 1, 2 or 4 bytes.
- **Lane mask:** lanes = ((1<<size)-1) << off, 7 bits wide.
- **Crossing:** the access crosses a word when lanes[6:4] != 0.
- **First transaction:** addr & ~3, `mem_be` = lanes[3:0], `mem_wdata` = low word of (zext64(wdata) << 8*off).
- **Second transaction:** (addr & ~3) + 4, `mem_be` = {1'b0, lanes[6:4]}, `mem_wdata` = high word of the same shift.
- **Load assembly:** d = ({word1, word0} >> 8*off)[31:0]. Truncate d to the access size, then sign-extend (BYTE, HALF) or zero-extend (BYTE_U, HALF_U).
- **Fault conditions** (decided in IDLE; no bus activity follows):
  - both read and write non-NONE;
  - read encoding 3'b110 or 3'b111;
  - addr < RAM_BASE, or addr+size-1 >= RAM_BASE+RAM_SIZE (compute in 33 bits);
  - crossing access when SPLIT_MISALIGNED=0.
- **Fault response:** `rsp_fault`=1, `rsp_rdata`=BAD_DATA.
- **Bus signal stability:** `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are held stable while `mem_req`=1. All four are 0 when `mem_req`=0.
- **Stray responses:** `mem_rvalid` outside WAIT0/WAIT1 is ignored.

## Timing
- **Reset values:**
  - `req_ready`=1.
  - `rsp_valid`, `rsp_fault`, `mem_req`, `mem_we`=0.
  - `mem_addr`, `mem_be`, `mem_wdata`, `rsp_rdata`=0.
  - State = IDLE.
- **Reset mid-operation:** abandons the transaction. `mem_req` drops asynchronously and no response is issued.
- **Registered outputs:** all outputs are registered except `req_ready`, which is decoded from state.
- **Latency**, with accept at cycle 0, `mem_gnt` in the same cycle as `mem_req`, and `mem_rvalid` one cycle after grant:
  - aligned access: `rsp_valid` at cycle 3;
  - split access: `rsp_valid` at cycle 5;
  - fault or NONE/NONE: `rsp_valid` at cycle 1.
- **Back-to-back:** a new request can be accepted in the cycle after DONE. Throughput is at most one aligned access per 4 cycles.
- **Wait states:** `mem_gnt` and `mem_rvalid` delays are unbounded. Each delay cycle extends latency 1:1.
- **Not supported:**
  - `mem_gnt` and `mem_rvalid` for the same transaction in the same cycle (`mem_rvalid` is only sampled in WAIT states).
  - Outstanding transactions beyond one.

## Test plan
- **Aligned LW:** LW at 0x1004, mem returns 0x12345678 → one transaction at 0x1004 with be 4'hF, `rsp_rdata`=0x12345678, `rsp_valid` at cycle 3.
- **Byte loads at 0x1007:** mem returns 0x80AABBCC.
  - LB → be 4'b1000, `rsp_rdata`=0xFFFFFF80.
  - LBU → `rsp_rdata`=0x00000080.
- **Split SW:** SW 0xAABBCCDD at 0x1002, SPLIT=1 → two transactions:
  - 0x1000, be 4'b1100, wdata 0xCCDD0000;
  - 0x1004, be 4'b0011, wdata 0x0000AABB;
  - then `rsp_valid` with `rsp_fault`=0.
- **Split LH at 0x1003:** words 0x80223344 and 0x556677FF.
  - SPLIT=1 → `rsp_rdata`=0xFFFFFF80.
  - SPLIT=0 → no `mem_req`, `rsp_fault`=1, `rsp_rdata`=0xDEADBEEF at cycle 1.
- **Range and encoding faults** (each → fault with no `mem_req`):
  - LW at 0x0FFC;
  - LH at 0x2FFF;
  - read=3'b111;
  - read=LW together with write=SW.
- **Stalls and reset:** hold `mem_gnt` low 3 cycles and delay `mem_rvalid` 2 cycles.
  - Required: `mem_req`, `mem_addr` and `mem_be` stay stable; `rsp_valid` at cycle 8.
  - Repeat with `rst_n` pulsed low during WAIT0 → all outputs go to reset values, no `rsp_valid`, and the next request is accepted normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Shared load/store encodings plus the pipeline-side and bus-side
// handshake bundles of the load/store unit.
package lsu_pkg;
    typedef enum logic [2:0] {
        RD_NONE   = 3'd0,
        RD_BYTE   = 3'd1,
        RD_HALF   = 3'd2,
        RD_WORD   = 3'd3,
        RD_BYTE_U = 3'd4,
        RD_HALF_U = 3'd5
    } mem_read_t;

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_BYTE = 2'd1,
        WR_HALF = 2'd2,
        WR_WORD = 2'd3
    } mem_write_t;
endpackage

interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_read;
    logic [1:0]  req_write;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_addr, req_wdata,
        output req_read, req_write,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, req_wdata,
        input  req_read, req_write,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: splits or faults misaligned accesses,
// range-checks against the RAM window and extends load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] RAM_BASE         = 32'h0000_1000,
    parameter logic [31:0] RAM_SIZE         = 32'h0000_2000,
    parameter bit          SPLIT_MISALIGNED = 1'b1,
    parameter logic [31:0] BAD_DATA         = 32'hdead_beef
) (
    input logic        clk,
    input logic        rst_n,
    lsu_req_if.slave   pipe,
    lsu_mem_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_ISSUE1,
        S_WAIT1,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  rd_q;
    logic [1:0]  wr_q;
    logic [31:0] word0_q;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        idle;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_rd;
    logic [1:0]  cur_wr;
    logic        is_rd;
    logic        is_wr;
    logic        sz_b;
    logic        sz_h;
    logic [2:0]  size;
    logic [1:0]  off;
    logic [6:0]  mask7;
    logic [6:0]  lanes;
    logic        crossing;
    logic [63:0] wshift;
    logic [32:0] last33;
    logic [32:0] win_end;
    logic        range_bad;
    logic        fault_c;
    logic        none_c;
    logic [63:0] pair;
    logic [31:0] d;
    logic [31:0] ext;
    logic [31:0] word_addr;

    assign idle      = (state_q == S_IDLE);
    assign cur_addr  = idle ? pipe.req_addr  : addr_q;
    assign cur_wdata = idle ? pipe.req_wdata : wdata_q;
    assign cur_rd    = idle ? pipe.req_read  : rd_q;
    assign cur_wr    = idle ? pipe.req_write : wr_q;

    assign is_rd = (cur_rd != RD_NONE);
    assign is_wr = (cur_wr != WR_NONE);
    assign off   = cur_addr[1:0];

    assign sz_b = (cur_rd == RD_BYTE) || (cur_rd == RD_BYTE_U)
                || (!is_rd && cur_wr == WR_BYTE);
    assign sz_h = (cur_rd == RD_HALF) || (cur_rd == RD_HALF_U)
                || (!is_rd && cur_wr == WR_HALF);

    always_comb begin
        size  = 3'd4;
        mask7 = 7'b000_1111;
        unique case (1'b1)
            sz_b: begin
                size  = 3'd1;
                mask7 = 7'b000_0001;
            end
            sz_h: begin
                size  = 3'd2;
                mask7 = 7'b000_0011;
            end
            default: begin
                size  = 3'd4;
                mask7 = 7'b000_1111;
            end
        endcase
    end

    assign lanes     = mask7 << off;
    assign crossing  = |lanes[6:4];
    assign wshift    = {32'b0, cur_wdata} << {off, 3'b000};
    assign word_addr = {cur_addr[31:2], 2'b00};

    // Window end compared in 33 bits so a top-of-space address cannot wrap.
    assign last33    = {1'b0, cur_addr} + {30'b0, size} - 33'd1;
    assign win_end   = {1'b0, RAM_BASE} + {1'b0, RAM_SIZE};
    assign range_bad = (cur_addr < RAM_BASE) || (last33 >= win_end);

    assign none_c  = !is_rd && !is_wr;
    assign fault_c = (is_rd && is_wr)
                   || (cur_rd[2:1] == 2'b11)
                   || (!none_c && range_bad)
                   || (!none_c && crossing && !SPLIT_MISALIGNED);

    assign pair = (state_q == S_WAIT1) ? {bus.mem_rdata, word0_q}
                                       : {32'b0, bus.mem_rdata};
    assign d    = 32'(pair >> {off, 3'b000});

    always_comb begin
        ext = d;
        unique case (cur_rd)
            RD_BYTE:   ext = {{24{d[7]}}, d[7:0]};
            RD_HALF:   ext = {{16{d[15]}}, d[15:0]};
            RD_BYTE_U: ext = {24'b0, d[7:0]};
            RD_HALF_U: ext = {16'b0, d[15:0]};
            default:   ext = d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            word0_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (idle && pipe.req_valid) begin
                addr_q  <= pipe.req_addr;
                wdata_q <= pipe.req_wdata;
                rd_q    <= pipe.req_read;
                wr_q    <= pipe.req_write;
            end
            if (state_q == S_WAIT0 && bus.mem_rvalid) begin
                word0_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pipe.req_valid) begin
                    state_d = (fault_c || none_c) ? S_DONE : S_ISSUE0;
                end
            end
            S_ISSUE0: if (bus.mem_gnt) state_d = S_WAIT0;
            S_WAIT0: begin
                if (bus.mem_rvalid) begin
                    state_d = crossing ? S_ISSUE1 : S_DONE;
                end
            end
            S_ISSUE1: if (bus.mem_gnt) state_d = S_WAIT1;
            S_WAIT1:  if (bus.mem_rvalid) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they can be registered.
    always_comb begin
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_be_d    = '0;
        mem_wdata_d = '0;
        rsp_valid_d = (state_d == S_DONE);
        rsp_fault_d = 1'b0;
        rsp_rdata_d = '0;
        if (state_d == S_ISSUE0) begin
            mem_req_d   = 1'b1;
            mem_we_d    = is_wr;
            mem_addr_d  = word_addr;
            mem_be_d    = lanes[3:0];
            mem_wdata_d = wshift[31:0];
        end else if (state_d == S_ISSUE1) begin
            mem_req_d   = 1'b1;
            mem_we_d    = is_wr;
            mem_addr_d  = word_addr + 32'd4;
            mem_be_d    = {1'b0, lanes[6:4]};
            mem_wdata_d = wshift[63:32];
        end
        if (rsp_valid_d && idle) begin
            rsp_fault_d = fault_c;
            rsp_rdata_d = fault_c ? BAD_DATA : 32'd0;
        end else if (rsp_valid_d) begin
            rsp_rdata_d = is_rd ? ext : 32'd0;
        end
    end

    assign pipe.req_ready = idle;
    assign pipe.rsp_valid = rsp_valid_q;
    assign pipe.rsp_fault = rsp_fault_q;
    assign pipe.rsp_rdata = rsp_rdata_q;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
